// File: rtl/l2_switch_pkg.sv
// l2_switch_pkg: shared widths, table entry layout and lookup FSM encoding for the L2 switch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_switch_pkg;

  localparam int PORT_NUM   = 4;
  localparam int MAC_W      = 48;
  localparam int MAC_IG_BIT = 40;
  localparam int PORT_W     = 2;

  // One MAC table entry; the age field lives beside it only in aging builds
  typedef struct packed {
    logic              vld;
    logic [MAC_W-1:0]  mac;
    logic [PORT_W-1:0] port;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_LEARN  = 2'd2,
    ST_RESP   = 2'd3
  } fsm_state_t;

  function automatic logic [PORT_NUM-1:0] port_onehot(input logic [PORT_W-1:0] port);
    logic [PORT_NUM-1:0] oh;
    oh       = '0;
    oh[port] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mac_hash_fold.sv
// mac_hash_fold: XOR-folds a MAC into a table index, slices taken from bit 0 upward, last slice zero-padded.
// Latency: combinational.
// Backpressure: none.
module mac_hash_fold #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  mac,
  output logic [OUT_W-1:0] idx
);

  localparam int NSLICE = (IN_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W  = NSLICE * OUT_W;

  logic [PAD_W-1:0] padded;

  // Zero-extend to a whole number of slices, then XOR them together
  always_comb begin
    padded = PAD_W'(mac);
    idx    = '0;
    for (int i = 0; i < NSLICE; i++) begin
      idx = idx ^ padded[i*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/mac_port_table.sv
// mac_port_table: direct-mapped source-learning MAC table; lookup dst, learn src, return egress mask.
// Latency: response valid 3 cycles after request accept; one request per 4 cycles with rsp_ready high.
// Backpressure: req_ready low from accept until the response is taken; response held while rsp_ready low.
// Optional aging is built only when PORT_TABLE_AGING_EN is defined.
module mac_port_table
  import l2_switch_pkg::*;
#(
  parameter int PORT_TABLE_ADDR_LEN = 3,
  parameter int AGE_MAX             = 15,
  parameter int AGE_TICK_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MAC_W-1:0]    req_dst_mac,
  input  logic [MAC_W-1:0]    req_src_mac,
  input  logic [PORT_W-1:0]   req_src_port,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PORT_NUM-1:0] rsp_port_mask,
  output logic                rsp_hit,
  input  logic [PORT_NUM-1:0] mask_port,
  input  logic                flush
);

  localparam int DEPTH = 1 << PORT_TABLE_ADDR_LEN;

  if (PORT_TABLE_ADDR_LEN < 1 || AGE_MAX < 1 || AGE_TICK_CYCLES < 2) begin : g_bad_param
    $error("mac_port_table: ADDR_LEN>=1, AGE_MAX>=1 and AGE_TICK_CYCLES>=2 required");
  end

  fsm_state_t                     state;
  logic [MAC_W-1:0]               dst_q;
  logic [MAC_W-1:0]               src_q;
  logic [PORT_W-1:0]              port_q;
  logic [PORT_TABLE_ADDR_LEN-1:0] dst_idx;
  logic [PORT_TABLE_ADDR_LEN-1:0] src_idx;
  entry_t [DEPTH-1:0]             tbl;
  entry_t                         dst_ent;
  logic                           lkp_hit;
  logic                           lkp_mcast;
  logic [PORT_NUM-1:0]            lkp_mask;
  logic                           learn_we;

  mac_hash_fold #(.IN_W(MAC_W), .OUT_W(PORT_TABLE_ADDR_LEN)) u_hash_dst (
    .mac (dst_q),
    .idx (dst_idx)
  );

  mac_hash_fold #(.IN_W(MAC_W), .OUT_W(PORT_TABLE_ADDR_LEN)) u_hash_src (
    .mac (src_q),
    .idx (src_idx)
  );

  // Forwarding decision for the registered request: flood on mcast/miss, filter same-port hits
  always_comb begin
    dst_ent   = tbl[dst_idx];
    lkp_mcast = dst_q[MAC_IG_BIT];
    lkp_hit   = dst_ent.vld && (dst_ent.mac == dst_q);
    if (lkp_mcast || !lkp_hit) begin
      lkp_mask = ~port_onehot(port_q);
    end else if (dst_ent.port == port_q) begin
      lkp_mask = '0;
    end else begin
      lkp_mask = port_onehot(dst_ent.port);
    end
    lkp_mask = lkp_mask & ~mask_port;
  end

  // Group-addressed sources are never learned
  assign learn_we = (state == ST_LEARN) && !src_q[MAC_IG_BIT];

  // Request FSM: accept, read the table, write the learn, then hold the response until taken
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_port_mask <= '0;
      rsp_hit       <= 1'b0;
      dst_q         <= '0;
      src_q         <= '0;
      port_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            dst_q     <= req_dst_mac;
            src_q     <= req_src_mac;
            port_q    <= req_src_port;
            req_ready <= 1'b0;
            state     <= ST_LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          rsp_port_mask <= lkp_mask;
          rsp_hit       <= lkp_hit && !lkp_mcast;
          state         <= ST_LEARN;
        end
        ST_LEARN: begin
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PORT_TABLE_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam int PS_W  = $clog2(AGE_TICK_CYCLES);

  logic [PS_W-1:0]             presc;
  logic                        tick;
  logic [DEPTH-1:0][AGE_W-1:0] age;

  assign tick = (presc == PS_W'(AGE_TICK_CYCLES - 1));

  // Free-running aging prescaler, one-cycle tick at wrap
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Table update: tick ages entries, a learn to the same slot overrides, flush overrides both
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tbl <= '0;
      age <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i].vld <= 1'b0;
        age[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tick && tbl[i].vld) begin
          if (age[i] > AGE_W'(1)) begin
            age[i] <= age[i] - 1'b1;
          end else begin
            tbl[i].vld <= 1'b0;
            age[i]     <= '0;
          end
        end
      end
      if (learn_we) begin
        tbl[src_idx] <= '{vld: 1'b1, mac: src_q, port: port_q};
        age[src_idx] <= AGE_W'(AGE_MAX);
      end
    end
  end
`else
  // Table update: learn overwrites the hashed slot; flush clears every valid bit and wins
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tbl <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i].vld <= 1'b0;
      end
    end else if (learn_we) begin
      tbl[src_idx] <= '{vld: 1'b1, mac: src_q, port: port_q};
    end
  end
`endif

endmodule

// File: tb/tb_mac_port_table.sv
// tb_mac_port_table: directed and randomized checks of mac_port_table against a reference table model.
// Latency: checks response at 3 cycles after accept and stability under rsp_ready backpressure.
// Backpressure: drives rsp_ready low for programmable hold periods. Aging steps need PORT_TABLE_AGING_EN.
module tb_mac_port_table;
  import l2_switch_pkg::*;

`ifdef PORT_TABLE_AGING_EN
  localparam int TB_AGE_MAX = 2;
  localparam int TB_TICK    = 4;
`else
  localparam int TB_AGE_MAX = 15;
  localparam int TB_TICK    = 100000000;
`endif
  localparam int ADDR  = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_dst_mac;
  logic [47:0] req_src_mac;
  logic [1:0]  req_src_port;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_port_mask;
  logic        rsp_hit;
  logic [3:0]  mask_port;
  logic        flush;

  int checks = 0;
  int fails  = 0;

  // Reference table: what the spec says the table holds, indexed by the bitwise fold
  logic        m_vld  [DEPTH];
  logic [47:0] m_mac  [DEPTH];
  logic [1:0]  m_port [DEPTH];

  logic [47:0] pool [10];
  logic [3:0]  om;
  logic        oh;

  localparam logic [47:0] MAC_A  = 48'h02000000000A;
  localparam logic [47:0] MAC_B  = 48'h02000000000B;
  localparam logic [47:0] MAC_C  = 48'h02000000000C;
  localparam logic [47:0] MAC_E  = 48'h02000000000E;
  localparam logic [47:0] MAC_X  = 48'h020000000008;
  localparam logic [47:0] MAC_Y  = 48'h020000000001;
  localparam logic [47:0] MAC_M  = 48'h01005E000001;
  localparam logic [47:0] MAC_D  = 48'h08005E000001;
  localparam logic [47:0] MAC_BC = 48'hFFFFFFFFFFFF;

  mac_port_table #(
    .PORT_TABLE_ADDR_LEN (ADDR),
    .AGE_MAX             (TB_AGE_MAX),
    .AGE_TICK_CYCLES     (TB_TICK)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dst_mac   (req_dst_mac),
    .req_src_mac   (req_src_mac),
    .req_src_port  (req_src_port),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_port_mask (rsp_port_mask),
    .rsp_hit       (rsp_hit),
    .mask_port     (mask_port),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index bit j is the parity of every MAC bit whose position is j modulo ADDR
  function automatic logic [ADDR-1:0] ref_hash(input logic [47:0] m);
    logic [ADDR-1:0] h;
    h = '0;
    for (int b = 0; b < 48; b++) h[b % ADDR] = h[b % ADDR] ^ m[b];
    return h;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic ref_learn(input logic [47:0] src, input logic [1:0] sp);
    logic [ADDR-1:0] i;
    if (!src[40]) begin
      i         = ref_hash(src);
      m_vld[i]  = 1'b1;
      m_mac[i]  = src;
      m_port[i] = sp;
    end
  endtask

  task automatic ref_expect(input logic [47:0] dst, input logic [1:0] sp, input logic [3:0] mp,
                            output logic [3:0] em, output logic eh);
    logic [ADDR-1:0] i;
    logic            hit;
    logic            mc;
    i   = ref_hash(dst);
    mc  = dst[40];
    hit = m_vld[i] && (m_mac[i] == dst);
    if (mc || !hit)            em = 4'hF & ~(4'b0001 << sp);
    else if (m_port[i] == sp)  em = 4'h0;
    else                       em = 4'b0001 << m_port[i];
    em = em & ~mp;
    eh = hit && !mc;
  endtask

  // One full request/response transaction with model comparison
  task automatic do_req(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] sp,
                        input logic [3:0] mp, input int hold, input logic do_flush,
                        output logic [3:0] obs_mask, output logic obs_hit);
    logic [3:0] em;
    logic       eh;
    int         w;
    ref_expect(dst, sp, mp, em, eh);
    @(negedge clk);
    req_valid    = 1'b1;
    req_dst_mac  = dst;
    req_src_mac  = src;
    req_src_port = sp;
    mask_port    = mp;
    rsp_ready    = (hold == 0);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 64'(w < 20), 64'd1);
    if (w >= 20) begin
      req_valid = 1'b0;
      obs_mask  = 'x;
      obs_hit   = 1'bx;
      return;
    end
    @(negedge clk);
    req_valid    = 1'b0;
    req_dst_mac  = 48'({$urandom(), $urandom()});
    req_src_mac  = 48'({$urandom(), $urandom()});
    req_src_port = 2'($urandom_range(0, 3));
    chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    mask_port = ~mp;
    flush     = do_flush;
    @(negedge clk);
    flush = 1'b0;
    chk("rsp_valid_t3", 64'(rsp_valid), 64'd1);
    chk("rsp_mask", 64'(rsp_port_mask), 64'(em));
    chk("rsp_hit", 64'(rsp_hit), 64'(eh));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    obs_mask = rsp_port_mask;
    obs_hit  = rsp_hit;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_mask", 64'(rsp_port_mask), 64'(em));
      chk("hold_hit", 64'(rsp_hit), 64'(eh));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
    ref_learn(src, sp);
    if (do_flush) ref_clear();
  endtask

  initial begin
    arst_n       = 1'b0;
    req_valid    = 1'b0;
    req_dst_mac  = '0;
    req_src_mac  = '0;
    req_src_port = '0;
    rsp_ready    = 1'b1;
    mask_port    = '0;
    flush        = 1'b0;
    ref_clear();
    for (int i = 0; i < 10; i++) begin
      pool[i]     = 48'({$urandom(), $urandom()});
      pool[i][40] = (i >= 8);
    end
    pool[9] = MAC_BC;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_mask", 64'(rsp_port_mask), 64'd0);
    chk("reset_hit", 64'(rsp_hit), 64'd0);
    arst_n = 1'b1;
    chk("release_req_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("release_req_ready_high", 64'(req_ready), 64'd1);

`ifdef PORT_TABLE_AGING_EN
    do_req(MAC_B, MAC_A, 2'd1, 4'h0, 0, 1'b0, om, oh);
    do_req(MAC_A, MAC_B, 2'd2, 4'h0, 0, 1'b0, om, oh);
    chk("age_fresh_mask", 64'(om), 64'h2);
    chk("age_fresh_hit", 64'(oh), 64'd1);
    repeat (12) @(negedge clk);
    ref_clear();
    do_req(MAC_A, MAC_C, 2'd3, 4'h0, 0, 1'b0, om, oh);
    chk("age_expired_mask", 64'(om), 64'h7);
    chk("age_expired_hit", 64'(oh), 64'd0);
    for (int d = 0; d < 4; d++) begin
      repeat (12) @(negedge clk);
      ref_clear();
      repeat (d) @(negedge clk);
      do_req(MAC_B, MAC_A, 2'd0, 4'h0, 0, 1'b0, om, oh);
      do_req(MAC_A, MAC_B, 2'd3, 4'h0, 0, 1'b0, om, oh);
      chk("age_relearn_mask", 64'(om), 64'h1);
      chk("age_relearn_hit", 64'(oh), 64'd1);
    end
`else
    do_req(MAC_B, MAC_A, 2'd1, 4'h0, 0, 1'b0, om, oh);
    chk("miss_flood_mask", 64'(om), 64'hD);
    chk("miss_flood_hit", 64'(oh), 64'd0);
    do_req(MAC_A, MAC_B, 2'd2, 4'h0, 0, 1'b0, om, oh);
    chk("unicast_hit_mask", 64'(om), 64'h2);
    chk("unicast_hit_hit", 64'(oh), 64'd1);
    do_req(MAC_A, MAC_B, 2'd1, 4'h0, 0, 1'b0, om, oh);
    chk("filter_mask", 64'(om), 64'h0);
    do_req(MAC_BC, MAC_C, 2'd3, 4'h4, 0, 1'b0, om, oh);
    chk("bcast_mask", 64'(om), 64'h3);
    chk("bcast_hit", 64'(oh), 64'd0);

    // D shares M's slot; a multicast source must not evict it
    do_req(MAC_B, MAC_D, 2'd0, 4'h0, 0, 1'b0, om, oh);
    do_req(MAC_A, MAC_M, 2'd2, 4'h0, 0, 1'b0, om, oh);
    do_req(MAC_D, MAC_C, 2'd3, 4'h0, 0, 1'b0, om, oh);
    chk("mcast_src_not_learned", 64'(om), 64'h1);

    // X and Y collide; the later learn evicts the earlier one
    do_req(MAC_C, MAC_X, 2'd0, 4'h0, 0, 1'b0, om, oh);
    do_req(MAC_C, MAC_Y, 2'd2, 4'h0, 0, 1'b0, om, oh);
    do_req(MAC_X, MAC_B, 2'd1, 4'h0, 0, 1'b0, om, oh);
    chk("collision_mask", 64'(om), 64'hD);
    chk("collision_hit", 64'(oh), 64'd0);

    do_req(MAC_Y, MAC_A, 2'd1, 4'h0, 10, 1'b1, om, oh);
    chk("flush_rsp_mask", 64'(om), 64'h4);
    do_req(MAC_Y, MAC_B, 2'd0, 4'h0, 0, 1'b0, om, oh);
    chk("post_flush_mask", 64'(om), 64'hE);
    chk("post_flush_hit", 64'(oh), 64'd0);

    do_req(MAC_E, MAC_E, 2'd1, 4'h0, 0, 1'b0, om, oh);
    chk("dst_eq_src_mask", 64'(om), 64'hD);
    do_req(MAC_E, MAC_A, 2'd2, 4'h0, 0, 1'b0, om, oh);
    chk("dst_eq_src_learned", 64'(om), 64'h2);

    for (int n = 0; n < 120; n++) begin
      do_req(pool[$urandom_range(0, 9)], pool[$urandom_range(0, 9)], 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
             int'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0), om, oh);
    end

    // Reset in the middle of a transaction drops it entirely
    @(negedge clk);
    req_valid   = 1'b1;
    req_dst_mac = pool[0];
    req_src_mac = pool[1];
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd0);
    chk("midreset_mask", 64'(rsp_port_mask), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    ref_clear();
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(pool[1], pool[0], 2'd0, 4'h0, 0, 1'b0, om, oh);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
